fp16_sum_normalize: RTL and testbench

Sequential normalize-and-round stage for the half-precision adder. It sits directly downstream of the FP16 exception-detection stage and consumes that stage's exception flag and result. It also consumes the raw aligned magnitude sum from the add datapath. It produces the final IEEE-754 binary16 sum over a valid/ready handshake, using an iterative one-bit-per-cycle left normalizer and round-to-nearest-even.

---
 rtl/fp16_sum_normalize_if.sv | 25 ++
 rtl/fp16_sum_normalize.sv | 186 ++++++++++++++++++
 tb/tb_fp16_sum_normalize.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_sum_normalize_if.sv
// fp16_sum_normalize_if: handshake and data bundle for the FP16 normalize-and-round stage.
// master = upstream producer / downstream consumer side, slave = the normalize stage.
interface fp16_sum_normalize_if;
   logic        IN_VALID;
   logic        IN_READY;
   logic        EXC;
   logic [15:0] EXC_Q;
   logic        SIGN_R;
   logic [4:0]  EXP_R;
   logic [14:0] RAW_MANT;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [15:0] Q;
   logic        EXC_OUT;

   modport master (
      output IN_VALID, EXC, EXC_Q, SIGN_R, EXP_R, RAW_MANT, OUT_READY,
      input  IN_READY, OUT_VALID, Q, EXC_OUT
   );

   modport slave (
      input  IN_VALID, EXC, EXC_Q, SIGN_R, EXP_R, RAW_MANT, OUT_READY,
      output IN_READY, OUT_VALID, Q, EXC_OUT
   );
endinterface

// File: rtl/fp16_sum_normalize.sv
// fp16_sum_normalize: normalizes the raw aligned magnitude sum of the FP16 adder,
// rounds it to nearest-even and returns the binary16 result over valid/ready.
// Exceptions from the upstream stage bypass the datapath.
// Optional macro FP16_NORM_FAST_SHIFT_EN: single-cycle leading-zero shifter instead of
// the default one-bit-per-cycle shifter (identical results, shorter latency).
module fp16_sum_normalize (
   input  logic                   clk,
   input  logic                   rst_n,
   fp16_sum_normalize_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [14:0] m_r;
   logic [14:0] m_nxt_s;
   logic [5:0]  e_r;
   logic [5:0]  e_nxt_s;
   logic        sign_hold_r;
   logic        sign_nxt_s;
   logic [15:0] q_r;
   logic [15:0] q_nxt_s;
   logic        exc_out_r;
   logic        exc_out_nxt_s;
   logic        out_valid_r;

   // A biased exponent of 0 (subnormal operand) has the same scale as exponent 1.
   logic [5:0]  exp_in_s;
   assign exp_in_s = (bus.EXP_R == 5'd0) ? 6'd1 : {1'b0, bus.EXP_R};

   // Round-to-nearest-even on the normalized working mantissa.
   logic        inc_s;
   logic [11:0] sum_s;
   logic        ovf_s;
   logic [10:0] sig_s;
   logic [5:0]  e_fin_s;
   logic        subn_s;
   logic [4:0]  exp_field_s;
   logic [15:0] round_q_s;

   assign inc_s       = m_r[2] & (m_r[1] | m_r[0] | m_r[3]);
   assign sum_s       = {1'b0, m_r[13:3]} + {11'd0, inc_s};
   assign ovf_s       = sum_s[11];
   assign sig_s       = ovf_s ? sum_s[11:1] : sum_s[10:0];
   assign e_fin_s     = e_r + {5'd0, ovf_s};
   // Hidden bit still clear after SHIFT means the exponent bottomed out at 1.
   assign subn_s      = ~m_r[13];
   // A subnormal that rounds up into the hidden bit becomes the smallest normal.
   assign exp_field_s = subn_s ? {4'd0, sig_s[10]} : e_fin_s[4:0];
   assign round_q_s   = (!subn_s && (e_fin_s >= 6'd31)) ? {sign_hold_r, 5'h1F, 10'h000}
                                                        : {sign_hold_r, exp_field_s, sig_s[9:0]};

`ifdef FP16_NORM_FAST_SHIFT_EN
   // Leading-zero count over the 14 bits below the carry position.
   function automatic logic [3:0] lzc14(input logic [13:0] v);
      logic [3:0] n;
      logic       found;
      n     = 4'd14;
      found = 1'b0;
      for (int i = 13; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 4'(13 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   logic [5:0] lzc_s;
   logic [5:0] emax_s;
   logic [5:0] k_s;
   assign lzc_s  = {2'b00, lzc14(m_r[13:0])};
   assign emax_s = e_r - 6'd1;
   assign k_s    = (lzc_s > emax_s) ? emax_s : lzc_s;
`endif

   assign bus.IN_READY  = (state_r == IDLE);
   assign bus.OUT_VALID = out_valid_r;
   assign bus.Q         = q_r;
   assign bus.EXC_OUT   = exc_out_r;

   // Next-state and datapath update for the normalize/round sequencer.
   always_comb begin
      state_nxt_s   = state_r;
      m_nxt_s       = m_r;
      e_nxt_s       = e_r;
      sign_nxt_s    = sign_hold_r;
      q_nxt_s       = q_r;
      exc_out_nxt_s = exc_out_r;
      case (state_r)
         IDLE: begin
            if (bus.IN_VALID) begin
               sign_nxt_s    = bus.SIGN_R;
               exc_out_nxt_s = bus.EXC;
               m_nxt_s       = bus.RAW_MANT;
               e_nxt_s       = exp_in_s;
               if (bus.EXC) begin
                  q_nxt_s     = bus.EXC_Q;
                  state_nxt_s = DONE;
               end else if (bus.RAW_MANT == 15'd0) begin
                  q_nxt_s     = 16'h0000;
                  state_nxt_s = DONE;
               end else if (bus.RAW_MANT[14]) begin
                  m_nxt_s     = {1'b0, bus.RAW_MANT[14:2], bus.RAW_MANT[1] | bus.RAW_MANT[0]};
                  e_nxt_s     = exp_in_s + 6'd1;
                  state_nxt_s = ROUND;
               end else begin
                  state_nxt_s = SHIFT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
`ifdef FP16_NORM_FAST_SHIFT_EN
            m_nxt_s     = m_r << k_s;
            e_nxt_s     = e_r - k_s;
            state_nxt_s = ROUND;
`else
            if (m_r[13] || (e_r == 6'd1)) begin
               state_nxt_s = ROUND;
            end else begin
               m_nxt_s = m_r << 1'b1;
               e_nxt_s = e_r - 6'd1;
               // Leave as soon as the shifted value is normalized or the exponent floor is hit.
               if (m_r[12] || (e_r == 6'd2)) begin
                  state_nxt_s = ROUND;
               end else begin
                  state_nxt_s = SHIFT;
               end
            end
`endif
         end
         ROUND: begin
            q_nxt_s     = round_q_s;
            e_nxt_s     = e_fin_s;
            state_nxt_s = DONE;
         end
         DONE: begin
            if (bus.OUT_READY) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register; reset discards any in-flight bundle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Working mantissa/exponent and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_r         <= 15'd0;
         e_r         <= 6'd0;
         sign_hold_r <= 1'b0;
         q_r         <= 16'h0000;
         exc_out_r   <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         m_r         <= m_nxt_s;
         e_r         <= e_nxt_s;
         sign_hold_r <= sign_nxt_s;
         q_r         <= q_nxt_s;
         exc_out_r   <= exc_out_nxt_s;
         out_valid_r <= (state_nxt_s == DONE);
      end
   end

endmodule

// File: tb/tb_fp16_sum_normalize.sv
// tb_fp16_sum_normalize: directed vectors for the FP16 normalize-and-round stage.
module tb_fp16_sum_normalize;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   fp16_sum_normalize_if bus ();

   fp16_sum_normalize dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef FP16_NORM_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   // Expected latency for a normal-path bundle needing n SHIFT iterations (n=0: carry-out).
   function automatic int exp_lat(input int n);
      if (n == 0) return 2;
      else if (FAST) return 3;
      else return 2 + n;
   endfunction

   // Present one bundle, wait for OUT_VALID, report result and latency.
   task automatic drive_vec(input logic exc, input logic [15:0] excq, input logic sign,
                            input logic [4:0] expr, input logic [14:0] raw,
                            output logic [15:0] q, output logic exo, output int lat);
      @(negedge clk);
      bus.EXC      = exc;
      bus.EXC_Q    = excq;
      bus.SIGN_R   = sign;
      bus.EXP_R    = expr;
      bus.RAW_MANT = raw;
      bus.IN_VALID = 1'b1;
      @(posedge clk);
      #1;
      bus.IN_VALID = 1'b0;
      lat = 1;
      while (!bus.OUT_VALID && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      q   = bus.Q;
      exo = bus.EXC_OUT;
   endtask

   task automatic complete_output();
      @(negedge clk);
      bus.OUT_READY = 1'b1;
      @(posedge clk);
      #1;
      bus.OUT_READY = 1'b0;
   endtask

   task automatic test_reset();
      checks += 4;
      if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.IN_READY); end
      if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.OUT_VALID); end
      if (bus.Q !== 16'h0000) begin failures++; $display("FAIL reset_q got=%h exp=0000", bus.Q); end
      if (bus.EXC_OUT !== 1'b0) begin failures++; $display("FAIL reset_exc_out got=%b exp=0", bus.EXC_OUT); end
   endtask

   task automatic test_exception();
      logic [15:0] q;
      logic        exo;
      int          lat;
      drive_vec(1'b1, 16'h7C00, 1'b0, 5'd15, 15'h2345, q, exo, lat);
      checks += 3;
      if (q !== 16'h7C00) begin failures++; $display("FAIL exc_q got=%h exp=7c00", q); end
      if (exo !== 1'b1) begin failures++; $display("FAIL exc_flag got=%b exp=1", exo); end
      if (lat != 1) begin failures++; $display("FAIL exc_latency got=%0d exp=1", lat); end
      complete_output();
      checks++;
      if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
         failures++;
         $display("FAIL exc_release got valid=%b ready=%b exp valid=0 ready=1", bus.OUT_VALID, bus.IN_READY);
      end
   endtask

   task automatic test_zero();
      logic [15:0] q;
      logic        exo;
      int          lat;
      drive_vec(1'b0, 16'hFFFF, 1'b1, 5'd20, 15'h0000, q, exo, lat);
      checks += 3;
      if (q !== 16'h0000) begin failures++; $display("FAIL zero_q got=%h exp=0000", q); end
      if (exo !== 1'b0) begin failures++; $display("FAIL zero_exc got=%b exp=0", exo); end
      if (lat != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
      complete_output();
   endtask

   task automatic test_normalize_round();
      // sign, EXP_R, RAW_MANT, expected Q, SHIFT iterations (0 = carry-out path)
      logic        v_sign [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [4:0]  v_exp  [10] = '{5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd30, 5'd1, 5'd3, 5'd0};
      logic [14:0] v_raw  [10] = '{15'h4000, 15'h200C, 15'h2004, 15'h2005, 15'h0008,
                                   15'h2000, 15'h7FFC, 15'h1000, 15'h0400, 15'h2000};
      logic [15:0] v_q    [10] = '{16'h4000, 16'h3C02, 16'h3C00, 16'hBC01, 16'h1400,
                                   16'h3C00, 16'h7C00, 16'h0200, 16'h0200, 16'h0400};
      int          v_n    [10] = '{0, 1, 1, 1, 10, 1, 0, 1, 2, 1};
      logic [15:0] q;
      logic        exo;
      int          lat;
      for (int i = 0; i < 10; i++) begin
         drive_vec(1'b0, 16'h0000, v_sign[i], v_exp[i], v_raw[i], q, exo, lat);
         checks += 3;
         if (q !== v_q[i]) begin
            failures++;
            $display("FAIL norm_q[%0d] raw=%h got=%h exp=%h", i, v_raw[i], q, v_q[i]);
         end
         if (exo !== 1'b0) begin
            failures++;
            $display("FAIL norm_exc[%0d] got=%b exp=0", i, exo);
         end
         if (lat != exp_lat(v_n[i])) begin
            failures++;
            $display("FAIL norm_latency[%0d] got=%0d exp=%0d", i, lat, exp_lat(v_n[i]));
         end
         complete_output();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] q;
      logic        exo;
      int          lat;
      drive_vec(1'b0, 16'h0000, 1'b0, 5'd15, 15'h2005, q, exo, lat);
      // Stall the consumer while a new bundle waits upstream.
      @(negedge clk);
      bus.EXC      = 1'b1;
      bus.EXC_Q    = 16'h1234;
      bus.IN_VALID = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks += 3;
         if (bus.Q !== 16'h3C01) begin failures++; $display("FAIL hold_q[%0d] got=%h exp=3c01", c, bus.Q); end
         if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", c, bus.IN_READY); end
         if (bus.OUT_VALID !== 1'b1) begin failures++; $display("FAIL hold_out_valid[%0d] got=%b exp=1", c, bus.OUT_VALID); end
      end
      bus.OUT_READY = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
         failures++;
         $display("FAIL b2b_release got valid=%b ready=%b exp valid=0 ready=1", bus.OUT_VALID, bus.IN_READY);
      end
      @(negedge clk);
      bus.OUT_READY = 1'b0;
      @(posedge clk);
      #1;
      bus.IN_VALID = 1'b0;
      bus.EXC      = 1'b0;
      checks += 3;
      if (bus.OUT_VALID !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", bus.OUT_VALID); end
      if (bus.Q !== 16'h1234) begin failures++; $display("FAIL b2b_q got=%h exp=1234", bus.Q); end
      if (bus.EXC_OUT !== 1'b1) begin failures++; $display("FAIL b2b_exc got=%b exp=1", bus.EXC_OUT); end
      complete_output();
   endtask

   task automatic test_reset_mid();
      logic [15:0] q;
      logic        exo;
      int          lat;
      @(negedge clk);
      bus.EXC      = 1'b0;
      bus.SIGN_R   = 1'b0;
      bus.EXP_R    = 5'd15;
      bus.RAW_MANT = 15'h0008;
      bus.IN_VALID = 1'b1;
      @(posedge clk);
      #1;
      bus.IN_VALID = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", bus.OUT_VALID); end
      if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", bus.IN_READY); end
      if (bus.Q !== 16'h0000) begin failures++; $display("FAIL midrst_q got=%h exp=0000", bus.Q); end
      if (bus.EXC_OUT !== 1'b0) begin failures++; $display("FAIL midrst_exc got=%b exp=0", bus.EXC_OUT); end
      @(negedge clk);
      rst_n = 1'b1;
      drive_vec(1'b0, 16'h0000, 1'b0, 5'd15, 15'h200C, q, exo, lat);
      checks += 2;
      if (q !== 16'h3C02) begin failures++; $display("FAIL postrst_q got=%h exp=3c02", q); end
      if (lat != exp_lat(1)) begin failures++; $display("FAIL postrst_latency got=%0d exp=%0d", lat, exp_lat(1)); end
      complete_output();
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.IN_VALID  = 1'b0;
      bus.EXC       = 1'b0;
      bus.EXC_Q     = 16'h0000;
      bus.SIGN_R    = 1'b0;
      bus.EXP_R     = 5'd0;
      bus.RAW_MANT  = 15'd0;
      bus.OUT_READY = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_exception();
      test_zero();
      test_normalize_round();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
